mem_burst_ctrl: RTL and testbench
=================================

// Module: mem_burst_ctrl
// PURPOSE
//  Parametrised memory controller between the JTAG controller and the on-chip memory.
//  Successor of the single-access controller. Adds configurable widths and a runtime access delay.
//  Adds optional memory-ack completion with timeout, and auto-incrementing read/fill bursts.
//  Sits in the clk domain. The request strobe sel arrives asynchronously from the TCK domain.
// PARAMETERS
//  ADDR_W      8   address width (mem_addr, addr)
//  DATA_W      16  data width (wdata, rdata, mem_wdata, mem_rdata)
//  DELAY_W     16  width of delay_cfg and the access counter
//  BURST_W     4   width of burst_len; a request carries up to 2**BURST_W beats
//  SYNC_STAGES 2   flops in the sel synchroniser (>=2)
//  USE_ACK     0   1: a beat also completes on mem_ack; delay_cfg then acts as the timeout
// PORTS
//  clk        in   1        system clock
//  sys_rst    in   1        synchronous, active-high reset
//  sel        in   1        request strobe from JTAG ctrl (async); rising edge starts a request
//  we         in   1        1 = write (fill) burst, 0 = read burst; sampled with the request
//  addr       in   ADDR_W   start address; sampled with the request
//  wdata      in   DATA_W   fill data, written at every beat; sampled with the request
//  burst_len  in   BURST_W  beats-1; sampled with the request
//  delay_cfg  in   DELAY_W  wait cycles per beat minus 1; sampled with the request
//  ready      out  1        1 = IDLE, a new request is accepted
//  rdata      out  DATA_W   last read beat data, held until the next read beat
//  rvalid     out  1        1-cycle pulse per captured read beat
//  err        out  1        sticky: ack timeout or a request dropped while busy
//  mem_rdata  in   DATA_W   memory read data
//  mem_ack    in   1        memory done (used only when USE_ACK=1)
//  mem_sel    out  1        memory select, high during ACCESS
//  mem_we     out  1        memory write enable
//  mem_addr   out  ADDR_W   memory address
//  mem_wdata  out  DATA_W   memory write data
// BEHAVIOUR
//  Reset (sync, priority over all): state=IDLE, ready=1.
//   All other outputs, counters and synchroniser flops are 0.
//   Asserting reset mid-burst aborts the burst in the next cycle. No further beats are issued.
//  Request detect: sel passes through SYNC_STAGES flops plus one history flop.
//   req = sync_out & ~hist.
//   mem_sel rises SYNC_STAGES+1 clk edges after the first edge that samples sel=1.
//  On req in IDLE, latch we, addr, wdata, burst_len and delay_cfg into mem_we, mem_addr,
//   mem_wdata, beat_cnt and dly. Then go to ACCESS and clear err.
//  On req outside IDLE: ignore the request, set err=1, leave the outputs unchanged.
//  FSM states: IDLE, ACCESS, GAP.
//   IDLE   -> ACCESS on req.
//   ACCESS -> GAP    on beat_done with beat_cnt!=0.
//   ACCESS -> IDLE   on beat_done with beat_cnt==0.
//   GAP    -> ACCESS always (exactly 1 cycle; mem_sel=0).
//  Access counter: 0 in the first ACCESS cycle of each beat, +1 per ACCESS cycle, 0 outside ACCESS.
//  beat_done when USE_ACK=0: cnt==dly. Each beat holds mem_sel high for dly+1 cycles.
//   dly=0 gives 1 cycle.
//  beat_done when USE_ACK=1: mem_ack | (cnt==dly).
//   If mem_ack=0 when cnt==dly (timeout), set err=1 and still complete the beat.
//   If mem_ack and timeout coincide, mem_ack wins and err is not set.
//  Read beat (mem_we=0): on beat_done, rdata<=mem_rdata and rvalid=1 in the next cycle.
//   On timeout, rdata is still captured.
//  On entering GAP: mem_addr<=mem_addr+1 (wraps modulo 2**ADDR_W, 'hFF->'h00 at default),
//   and beat_cnt<=beat_cnt-1.
//  mem_we and mem_wdata are constant for the whole burst. mem_addr holds after the last beat.
//  ready = (state==IDLE). mem_sel = (state==ACCESS).
// STRUCTURE
//  mem_ctrl_pkg: state enum (IDLE/ACCESS/GAP).
//   Also default constants: DEF_ADDR_W, DEF_DATA_W, DEF_DELAY_W, DEF_BURST_W.
//  Sub-module sync_rise_det #(STAGES): reset to 0, async bit -> 1-cycle rise pulse.
//  FSM, beat and access counters, and the datapath live in mem_burst_ctrl.
// TESTING
//  Single read: addr=0x10, burst_len=0, delay_cfg=15, mem_rdata=0xBEEF.
//   -> mem_sel high 16 cycles, rdata=0xBEEF, one rvalid pulse, ready back to 1.
//  Fill burst: we=1, addr=0xFE, wdata=0xA5A5, burst_len=3, delay_cfg=0.
//   -> 4 one-cycle beats at 0xFE, 0xFF, 0x00, 0x01 with a 1-cycle gap between beats.
//  USE_ACK=1, delay_cfg=7, mem_ack at cnt=2 -> 3-cycle beat, err=0.
//   With no ack -> 8-cycle beat and err=1.
//  Second sel rise during a burst -> err=1, the burst finishes unchanged.
//   The next accepted request clears err.
//  sys_rst=1 mid-burst (beat 2 of 4) -> next cycle: ready=1, mem_sel=0, all outputs 0.
//   No further beats after reset is released.
//  sel pulse lasting SYNC_STAGES+1 cycles -> exactly one request, latency SYNC_STAGES+1.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the burst memory controller.
package mem_ctrl_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_DELAY_W = 16;
    localparam int DEF_BURST_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        GAP    = 2'd2
    } state_t;

endpackage

// File: rtl/sync_rise_det.sv
// Synchronises an asynchronous strobe into clk and emits a one-cycle pulse on its rising edge.
module sync_rise_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    // Shift the strobe through the synchroniser; the history flop remembers the last synced value.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        hist_d = sync_q[STAGES-1];
    end

    // Synchroniser and history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst memory controller: accepts a JTAG-side request and issues one or more memory beats,
// each held for a programmable number of cycles or until the memory acknowledges.
module mem_burst_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DELAY_W     = DEF_DELAY_W,
    parameter int BURST_W     = DEF_BURST_W,
    parameter int SYNC_STAGES = 2,
    parameter int USE_ACK     = 0
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [DELAY_W-1:0] delay_cfg,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam logic ACK_EN = (USE_ACK != 0);

    state_t             state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [DELAY_W-1:0] dly_q, dly_d;
    logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               mem_sel_q, mem_sel_d;

    logic req;
    logic in_access;
    logic cnt_hit;
    logic beat_done;
    logic timeout;

    sync_rise_det #(.STAGES(SYNC_STAGES)) u_sel_det (
        .clk      (clk),
        .rst      (sys_rst),
        .async_in (sel),
        .rise     (req)
    );

    // Next-state logic for the FSM, the access/beat counters and the datapath.
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        beat_cnt_d  = beat_cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;

        in_access = (state_q == ACCESS);
        cnt_hit   = in_access && (cnt_q == dly_q);
        // An ack arriving on the last allowed cycle wins over the timeout.
        beat_done = cnt_hit || (ACK_EN && in_access && mem_ack);
        timeout   = ACK_EN && cnt_hit && !mem_ack;

        cnt_d    = (in_access && !beat_done) ? cnt_q + DELAY_W'(1) : '0;
        rvalid_d = beat_done && !mem_we_q;
        if (beat_done && !mem_we_q) begin
            rdata_d = mem_rdata;
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    mem_we_d    = we;
                    mem_addr_d  = addr;
                    mem_wdata_d = wdata;
                    beat_cnt_d  = burst_len;
                    dly_d       = delay_cfg;
                    err_d       = 1'b0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (beat_done) begin
                    if (beat_cnt_q != '0) begin
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                        beat_cnt_d = beat_cnt_q - BURST_W'(1);
                        state_d    = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                state_d = ACCESS;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A request while busy is dropped but flagged; a timed-out beat is flagged too.
        if ((req && state_q != IDLE) || timeout) begin
            err_d = 1'b1;
        end

        ready_d   = (state_d == IDLE);
        mem_sel_d = (state_d == ACCESS);
    end

    // All state and registered outputs; reset clears everything and returns to IDLE.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dly_q       <= '0;
            beat_cnt_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            mem_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dly_q       <= dly_d;
            beat_cnt_q  <= beat_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            mem_sel_q   <= mem_sel_d;
        end
    end

    assign ready     = ready_q;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign err       = err_q;
    assign mem_sel   = mem_sel_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: one instance without ack completion, one with, driven in parallel.
module tb_mem_burst_ctrl;

    localparam int S = 2;

    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic [15:0] wdata;
        int          len;
        logic        first;
    } beat_t;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        sel;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [3:0]  burst_len;
    logic [15:0] delay_cfg;
    logic        mem_ack;
    logic [15:0] rd_seed;

    logic        ready_w    [2];
    logic [15:0] rdata_w    [2];
    logic        rvalid_w   [2];
    logic        err_w      [2];
    logic [15:0] mem_rdata_w[2];
    logic        mem_sel_w  [2];
    logic        mem_we_w   [2];
    logic [7:0]  mem_addr_w [2];
    logic [15:0] mem_wdata_w[2];

    int    errors = 0;
    int    checks = 0;
    int    ack_at = 255;
    int    ack_idx = 0;
    int    starts [2] = '{0, 0};
    logic  in_beat[2] = '{1'b0, 1'b0};
    logic  err_exp[2];

    beat_t       bq0[$];
    beat_t       bq1[$];
    logic [15:0] rq0[$];
    logic [15:0] rq1[$];

    always #5 clk = ~clk;

    // Memory read data model: a seed mixed with the address being accessed.
    assign mem_rdata_w[0] = rd_seed ^ {mem_addr_w[0], mem_addr_w[0]};
    assign mem_rdata_w[1] = rd_seed ^ {mem_addr_w[1], mem_addr_w[1]};

    mem_burst_ctrl #(.SYNC_STAGES(S), .USE_ACK(0)) dut0 (
        .clk(clk), .sys_rst(sys_rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
        .burst_len(burst_len), .delay_cfg(delay_cfg), .ready(ready_w[0]), .rdata(rdata_w[0]),
        .rvalid(rvalid_w[0]), .err(err_w[0]), .mem_rdata(mem_rdata_w[0]), .mem_ack(mem_ack),
        .mem_sel(mem_sel_w[0]), .mem_we(mem_we_w[0]), .mem_addr(mem_addr_w[0]),
        .mem_wdata(mem_wdata_w[0])
    );

    mem_burst_ctrl #(.SYNC_STAGES(S), .USE_ACK(1)) dut1 (
        .clk(clk), .sys_rst(sys_rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
        .burst_len(burst_len), .delay_cfg(delay_cfg), .ready(ready_w[1]), .rdata(rdata_w[1]),
        .rvalid(rvalid_w[1]), .err(err_w[1]), .mem_rdata(mem_rdata_w[1]), .mem_ack(mem_ack),
        .mem_sel(mem_sel_w[1]), .mem_we(mem_we_w[1]), .mem_addr(mem_addr_w[1]),
        .mem_wdata(mem_wdata_w[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int bq_size(input int d);
        return (d == 0) ? bq0.size() : bq1.size();
    endfunction

    function automatic int rq_size(input int d);
        return (d == 0) ? rq0.size() : rq1.size();
    endfunction

    // Memory model for the ack instance: ack on beat cycle ack_at (0 = first ACCESS cycle).
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_sel_w[1]) begin
                mem_ack = (ack_idx == ack_at);
                ack_idx++;
            end else begin
                mem_ack = 1'b0;
                ack_idx = 0;
            end
        end
    end

    // Monitor: measures each beat on the memory side and each read return, compares to scoreboard.
    task automatic monitor(input int d);
        int          len = 0;
        int          lowcnt = 0;
        beat_t       b;
        logic [7:0]  a0 = '0;
        logic        w0 = 1'b0;
        logic [15:0] wd0 = '0;
        logic [15:0] r;
        forever begin
            @(negedge clk);
            if (mem_sel_w[d]) begin
                if (!in_beat[d]) begin
                    in_beat[d] = 1'b1;
                    starts[d]++;
                    len = 1;
                    a0  = mem_addr_w[d];
                    w0  = mem_we_w[d];
                    wd0 = mem_wdata_w[d];
                    if (bq_size(d) > 0) begin
                        b = (d == 0) ? bq0[0] : bq1[0];
                        if (!b.first) chk($sformatf("gap_len dut%0d", d), lowcnt, 1);
                    end
                end else begin
                    len++;
                end
            end else if (in_beat[d]) begin
                in_beat[d] = 1'b0;
                lowcnt = 1;
                if (bq_size(d) == 0) begin
                    chk($sformatf("unexpected_beat dut%0d", d), 1, 0);
                end else begin
                    if (d == 0) b = bq0.pop_front(); else b = bq1.pop_front();
                    chk($sformatf("beat_len dut%0d", d), len, b.len);
                    chk($sformatf("beat_addr dut%0d", d), a0, b.addr);
                    chk($sformatf("beat_we dut%0d", d), w0, b.we);
                    chk($sformatf("beat_wdata dut%0d", d), wd0, b.wdata);
                end
            end else begin
                lowcnt++;
            end
            if (rvalid_w[d]) begin
                if (rq_size(d) == 0) begin
                    chk($sformatf("unexpected_rvalid dut%0d", d), 1, 0);
                end else begin
                    if (d == 0) r = rq0.pop_front(); else r = rq1.pop_front();
                    chk($sformatf("rdata dut%0d", d), rdata_w[d], r);
                end
            end
        end
    endtask

    initial fork
        monitor(0);
        monitor(1);
    join_none

    task automatic wait_idle();
        int n = 0;
        while (!(ready_w[0] && ready_w[1]) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 0, 1);
    endtask

    // Reference model: a burst of burst_len+1 beats at consecutive (wrapping) addresses.
    task automatic push_expect(input logic iwe, input logic [7:0] iaddr, input logic [15:0] iwdata,
                               input int nbeats, input int idly, input int iack);
        beat_t b;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < nbeats; i++) begin
                b.addr  = 8'(iaddr + i);
                b.we    = iwe;
                b.wdata = iwdata;
                b.first = (i == 0);
                b.len   = (d == 1 && iack <= idly) ? iack + 1 : idly + 1;
                if (d == 0) bq0.push_back(b); else bq1.push_back(b);
                if (!iwe) begin
                    if (d == 0) rq0.push_back(rd_seed ^ {b.addr, b.addr});
                    else        rq1.push_back(rd_seed ^ {b.addr, b.addr});
                end
            end
        end
    endtask

    task automatic pulse_request(input logic chk_lat);
        int first_k = 0;
        sel = 1'b1;
        for (int k = 1; k <= S + 1; k++) begin
            @(posedge clk);
            #1;
            if (first_k == 0 && mem_sel_w[0]) first_k = k;
        end
        sel = 1'b0;
        if (chk_lat) chk("req_latency", first_k, S + 1);
    endtask

    task automatic issue(input logic iwe, input logic [7:0] iaddr, input logic [15:0] iwdata,
                         input logic [3:0] iblen, input logic [15:0] idly, input int iack,
                         input logic [15:0] iseed, input int drop_at);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        rd_seed   = iseed;
        ack_at    = iack;
        we        = iwe;
        addr      = iaddr;
        wdata     = iwdata;
        burst_len = iblen;
        delay_cfg = idly;
        push_expect(iwe, iaddr, iwdata, int'(iblen) + 1, int'(idly), iack);
        err_exp[0] = (drop_at > 0);
        err_exp[1] = (drop_at > 0) || (iack > int'(idly));
        pulse_request(1'b1);
        if (drop_at > 0) begin
            repeat (drop_at) @(posedge clk);
            #1;
            we   = ~iwe;
            addr = ~iaddr;
            pulse_request(1'b0);
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("err dut0", err_w[0], err_exp[0]);
        chk("err dut1", err_w[1], err_exp[1]);
        chk("ready dut0", ready_w[0], 1);
    endtask

    task automatic check_reset_state();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ready dut%0d", d), ready_w[d], 1);
            chk($sformatf("rst_mem_sel dut%0d", d), mem_sel_w[d], 0);
            chk($sformatf("rst_mem_we dut%0d", d), mem_we_w[d], 0);
            chk($sformatf("rst_mem_addr dut%0d", d), mem_addr_w[d], 0);
            chk($sformatf("rst_mem_wdata dut%0d", d), mem_wdata_w[d], 0);
            chk($sformatf("rst_rdata dut%0d", d), rdata_w[d], 0);
            chk($sformatf("rst_rvalid dut%0d", d), rvalid_w[d], 0);
            chk($sformatf("rst_err dut%0d", d), err_w[d], 0);
        end
    endtask

    initial begin
        int s0;
        int n;
        sys_rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        burst_len = '0; delay_cfg = '0; rd_seed = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        sys_rst = 1'b0;

        // Single read, 16-cycle beat, returns 0xBEEF.
        issue(1'b0, 8'h10, 16'h0000, 4'd0, 16'd15, 15, 16'hBEEF ^ 16'h1010, 0);
        // Fill burst wrapping through 0xFF -> 0x00.
        issue(1'b1, 8'hFE, 16'hA5A5, 4'd3, 16'd0, 0, 16'h1234, 0);
        // Ack at cycle 2 of 8 (dut1 3-cycle beat), then no ack (timeout).
        issue(1'b0, 8'h40, 16'h0000, 4'd0, 16'd7, 2, 16'h3C3C, 0);
        issue(1'b0, 8'h41, 16'h0000, 4'd1, 16'd7, 255, 16'h7777, 0);
        // Request dropped while busy; next accepted request clears err.
        issue(1'b1, 8'h80, 16'h5A5A, 4'd3, 16'd10, 4, 16'h0000, 6);
        issue(1'b0, 8'h90, 16'h0000, 4'd1, 16'd2, 2, 16'hC001, 0);

        // Reset mid-burst during beat 2 of 4.
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        ack_at = 3; we = 1'b1; addr = 8'h20; wdata = 16'h1111; burst_len = 4'd3; delay_cfg = 16'd3;
        push_expect(1'b1, 8'h20, 16'h1111, 4, 3, 3);
        s0 = starts[0];
        pulse_request(1'b1);
        n = 0;
        while (starts[0] < s0 + 2 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("second_beat_timeout", 0, 1);
        sys_rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state();
        bq0.delete(); bq1.delete(); rq0.delete(); rq1.delete();
        in_beat[0] = 1'b0; in_beat[1] = 1'b0;
        s0 = starts[0];
        sys_rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("no_beats_after_reset", starts[0], s0);
        chk("idle_after_reset", ready_w[0], 1);

        // Randomised bursts against the reference model.
        for (int t = 0; t < 10; t++) begin
            issue(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
                  4'($urandom_range(0, 3)), 16'($urandom_range(0, 5)),
                  int'($urandom_range(0, 7)), 16'($urandom), 0);
        end

        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("beats_left dut0", bq0.size(), 0);
        chk("beats_left dut1", bq1.size(), 0);
        chk("reads_left dut0", rq0.size(), 0);
        chk("reads_left dut1", rq1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
